// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset vector and PC step.
package mips_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    DECODE = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: JR > J/JAL > branch > sequential, all 32-bit modulo.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        PCSrc1,
  input  logic        PCSrc2,
  input  logic        PCSrc3,
  input  logic [25:0] jump_index,
  input  logic [15:0] branch_imm,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;

  assign pc_plus4 = pc + PC_INCR;
  assign br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (PCSrc3) begin
      // Misaligned JR targets are forced to a word boundary; the error is flagged upstream.
      next_pc = {rs_data[31:2], 2'b00};
    end else if (PCSrc1) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (PCSrc2) begin
      next_pc = pc_plus4 + $unsigned(br_off);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: requests a word, latches it for decode,
// then advances the PC from the control-selected next-PC source.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        PCSrc1,
  input  logic        PCSrc2,
  input  logic        PCSrc3,
  input  logic [25:0] jump_index,
  input  logic [15:0] branch_imm,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        addr_err
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  fetch_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       next_pc;

  next_pc_sel u_next_pc_sel (
    .pc         (pc_out),
    .PCSrc1     (PCSrc1),
    .PCSrc2     (PCSrc2),
    .PCSrc3     (PCSrc3),
    .jump_index (jump_index),
    .branch_imm (branch_imm),
    .rs_data    (rs_data),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc)
  );

  assign imem_addr = pc_out;

  // imem_req is registered, so the first request after reset appears one
  // edge after release and a returned word is only accepted while it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc_out      <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      addr_err    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_ready) begin
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= DECODE;
          end else if (imem_req) begin
            if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WAIT_ONE;
            if (wait_cnt == WAIT_LAST) addr_err <= 1'b1;
          end
        end
        DECODE: begin
          if (!stall) begin
            pc_out      <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            wait_cnt    <= '0;
            state       <= FETCH;
            if (PCSrc3 && (rs_data[1:0] != 2'b00)) addr_err <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
